uart_tx_stream: RTL and testbench

Parametrised, buffered UART transmitter for the AES datapath's serial output. It accepts words over a valid/ready handshake into an internal FIFO and serialises them back-to-back with no idle gap. Data width, parity, stop bits and FIFO depth are configurable at build time; the baud divisor is selectable at run time. It replaces the fixed 8N1 unbuffered transmitter in the UART subsystem.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_stream.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding, parity helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_EVEN   = 1;
    localparam int PARITY_ODD    = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    // Zero-extended data does not change the XOR, so one width covers every DATA_BITS.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read data; one-cycle write-to-read latency.
// Pushes are dropped when full and pops ignored when empty; the caller gates with full/empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter; first start bit leaves the cycle after the pop edge, frames back-to-back.
// ready_o drops when the FIFO is full (no same-cycle pop credit) and is held low during reset.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic [DIV_WIDTH-1:0]          baud_div_i,
    input  logic [DATA_BITS-1:0]          din_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          tx_done_tick_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_tx_state_t state, state_d;

    logic                 push;
    logic                 pop;
    logic                 load;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] rd_data;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_nxt;

    logic [DIV_WIDTH-1:0] timer, timer_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           bit_idx, bit_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q;
    logic                 expire;

    assign ready_o   = !full && !rst_i;
    assign push      = valid_i && ready_o;
    assign expire    = (timer == div_q - DIV_WIDTH'(1));
    assign count_nxt = fifo_count + CW'(push) - CW'(pop);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_i),
        .push    (push),
        .pop     (pop),
        .wr_data (din_i),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d = state;
        timer_d = expire ? '0 : timer + DIV_WIDTH'(1);
        bit_d   = bit_idx;
        shreg_d = shreg;
        par_d   = par_q;
        div_d   = div_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                if (!empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (expire) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shreg[0];
                end
            end
            ST_DATA: begin
                tx_d = shreg[0];
                if (expire) begin
                    if (bit_idx == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // tx_o is registered, so present the bit that the shift exposes next.
                        bit_d   = bit_idx + 4'd1;
                        shreg_d = shreg >> 1;
                        tx_d    = shreg[1];
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_q;
                if (expire) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (expire) begin
                    if (bit_idx == LAST_STOP) begin
                        done_d = 1'b1;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: pop, capture word, parity and divisor so mid-frame input changes are ignored.
        if (load) begin
            pop     = 1'b1;
            state_d = ST_START;
            shreg_d = rd_data;
            par_d   = parity_bit(MAX_DATA_BITS'(rd_data), PARITY);
            div_d   = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;
            timer_d = '0;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            div_q   <= DIV_WIDTH'(1);
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            bit_idx <= bit_d;
            shreg   <= shreg_d;
            par_q   <= par_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= (state_d != ST_IDLE) || (count_nxt != '0);
        end
    end

    assign tx_o           = tx_q;
    assign tx_done_tick_o = done_q;
    assign busy_o         = busy_q;
    assign fifo_count_o   = fifo_count;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Drives 8N1, 8E2 and 7O1 transmitters with shared stimulus and compares every cycle
// against a frame-level model (word queue plus precomputed line levels per frame).
module tb_uart_tx_stream;

    localparam int NDUT  = 3;
    localparam int DEPTH = 4;
    localparam int DB  [NDUT] = '{8, 8, 7};
    localparam int PAR [NDUT] = '{0, 1, 2};
    localparam int SB  [NDUT] = '{1, 2, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  din;
    logic [15:0] baud;

    logic [NDUT-1:0] tx;
    logic [NDUT-1:0] ready;
    logic [NDUT-1:0] busy;
    logic [NDUT-1:0] done;
    logic [2:0]      cnt [NDUT];

    always #5 clk = ~clk;

    uart_tx_stream #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut_8n1 (
        .clk(clk), .rst_i(rst), .baud_div_i(baud), .din_i(din[7:0]), .valid_i(valid),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .tx_done_tick_o(done[0]),
        .fifo_count_o(cnt[0]));

    uart_tx_stream #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut_8e2 (
        .clk(clk), .rst_i(rst), .baud_div_i(baud), .din_i(din[7:0]), .valid_i(valid),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .tx_done_tick_o(done[1]),
        .fifo_count_o(cnt[1]));

    uart_tx_stream #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut_7o1 (
        .clk(clk), .rst_i(rst), .baud_div_i(baud), .din_i(din[6:0]), .valid_i(valid),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .tx_done_tick_o(done[2]),
        .fifo_count_o(cnt[2]));

    // Reference model state
    int q    [NDUT][$];
    bit fb   [NDUT][16];
    int flen [NDUT];
    int fdiv [NDUT];
    int pos  [NDUT];
    int act  [NDUT];
    int e_done [NDUT];

    int n_cmp = 0;
    int n_err = 0;
    int chk_en = 0;
    int cyc = 0;
    int n_done  [NDUT];
    int t_start [NDUT];
    int t_done  [NDUT];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic void build_frame(input int k, input int w);
        int n;
        int p;
        n = 0;
        p = 0;
        fb[k][n++] = 1'b0;
        for (int i = 0; i < DB[k]; i++) begin
            fb[k][n++] = bit'((w >> i) & 1);
            p ^= (w >> i) & 1;
        end
        if (PAR[k] != 0) begin
            fb[k][n++] = bit'(p ^ ((PAR[k] == 2) ? 1 : 0));
        end
        for (int i = 0; i < SB[k]; i++) begin
            fb[k][n++] = 1'b1;
        end
        flen[k] = n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            int mw;
            bit mpush;
            if (rst) begin
                q[k].delete();
                act[k]    = 0;
                e_done[k] = 0;
            end else begin
                mpush     = valid && (q[k].size() < DEPTH);
                e_done[k] = 0;
                if (act[k] != 0) begin
                    pos[k]++;
                    if (pos[k] == flen[k] * fdiv[k]) begin
                        act[k]    = 0;
                        e_done[k] = 1;
                    end
                end
                if (act[k] == 0 && q[k].size() > 0) begin
                    mw = q[k].pop_front();
                    build_frame(k, mw);
                    fdiv[k] = (baud == 0) ? 1 : int'(baud);
                    pos[k]  = 0;
                    act[k]  = 1;
                end
                if (mpush) begin
                    q[k].push_back(int'(din) & ((1 << DB[k]) - 1));
                end
            end
        end
    end

    task automatic check_cycle();
        for (int k = 0; k < NDUT; k++) begin
            int etx;
            etx = (act[k] != 0) ? int'(fb[k][pos[k] / fdiv[k]]) : 1;
            check_eq($sformatf("tx%0d", k), int'(tx[k]), etx);
            check_eq($sformatf("done%0d", k), int'(done[k]), e_done[k]);
            check_eq($sformatf("count%0d", k), int'(cnt[k]), q[k].size());
            check_eq($sformatf("busy%0d", k), int'(busy[k]), ((act[k] != 0) || (q[k].size() != 0)) ? 1 : 0);
            check_eq($sformatf("ready%0d", k), int'(ready[k]), rst ? 0 : ((q[k].size() < DEPTH) ? 1 : 0));
            if (done[k]) n_done[k]++;
            if (t_start[k] < 0 && tx[k] == 1'b0) t_start[k] = cyc;
            if (t_done[k] < 0 && done[k]) t_done[k] = cyc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (chk_en != 0) check_cycle();
    endtask

    task automatic arm();
        for (int k = 0; k < NDUT; k++) begin
            t_start[k] = -1;
            t_done[k]  = -1;
            n_done[k]  = 0;
        end
    endtask

    task automatic single_frame(input logic [7:0] w, input int div);
        baud  = 16'(div);
        din   = w;
        valid = 1'b1;
        arm();
        step();
        valid = 1'b0;
        repeat (60) step();
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("frame_len%0d", k), t_done[k] - t_start[k],
                     (1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + SB[k]) * div);
            check_eq($sformatf("frame_dones%0d", k), n_done[k], 1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        din   = '0;
        baud  = 16'd4;
        arm();
        @(posedge clk);
        chk_en = 1;
        step();
        step();
        rst = 1'b0;
        step();

        single_frame(8'hA5, 4);
        single_frame(8'h07, 3);
        single_frame(8'h00, 2);

        // Five words back-to-back into a depth-4 FIFO
        baud = 16'd2;
        arm();
        for (int i = 0; i < 5; i++) begin
            din   = 8'(8'h11 + i);
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
        repeat (150) step();
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("burst_dones%0d", k), n_done[k], 5);
        end

        // Divisor change mid-frame
        baud = 16'd4;
        din = 8'h3C; valid = 1'b1; step();
        din = 8'hC3; step();
        valid = 1'b0;
        repeat (10) step();
        baud = 16'd8;
        repeat (200) step();

        // Reset during the second of three queued frames
        baud = 16'd4;
        for (int i = 0; i < 3; i++) begin
            din   = 8'(8'h5A ^ (i * 8'h33));
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
        repeat (52) step();
        rst = 1'b1;
        arm();
        step();
        rst = 1'b0;
        repeat (80) step();
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("post_reset_dones%0d", k), n_done[k], 0);
            check_eq($sformatf("post_reset_starts%0d", k), t_start[k], -1);
        end

        // Randomised traffic with occasional divisor changes and resets
        baud = 16'd1;
        for (int i = 0; i < 3000; i++) begin
            int vprob;
            vprob = (i / 500) % 3;
            valid = ($urandom_range(0, 3) < vprob + 1);
            din   = 8'($urandom);
            if ($urandom_range(0, 149) == 0) baud = 16'($urandom_range(0, 4));
            rst   = ($urandom_range(0, 799) == 0);
            step();
        end
        rst   = 1'b0;
        valid = 1'b0;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
